// File: rtl/sseg_pkg.sv
// Shared segment encoding for the seven-segment scan driver.
// o_sseg_n bit order: bit7 = DP, bits6..0 = G,F,E,D,C,B,A; all active-low.
package sseg_pkg;

    localparam int          SSEG_DP_BIT  = 7;
    localparam logic [7:0]  SSEG_BLANK_N = 8'hFF;
    localparam logic [6:0]  SEG_OFF_N    = 7'h7F;

    function automatic logic [6:0] hex_to_sseg_n(input logic [3:0] hex);
        logic [6:0] seg;
        seg = SEG_OFF_N;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_OFF_N;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sseg_slot_timer.sv
// Slot/digit counters, frame pulse, blink phase and PWM window for the scan driver.
// o_frame_start and o_blink_hide are combinational views of the current/next state.
module sseg_slot_timer
    import sseg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int DIGIT_CYCLES = 100_000,
    parameter int GUARD        = 8,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_FRAMES = 250,
    parameter int IDX_W        = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [BRIGHT_W-1:0] i_brightness,
    output logic [IDX_W-1:0]    o_idx,
    output logic                o_frame_start,
    output logic                o_frame,
    output logic                o_blink_hide,
    output logic                o_sel_on
);

    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int ON_W  = BRIGHT_W + $clog2(DIGIT_CYCLES) + 1;
    localparam int BF_W  = $clog2(BLINK_FRAMES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BF_W-1:0]  fcnt_q, fcnt_d;
    logic             phase_q, phase_d;
    logic             frame_q;
    logic             frame_start;
    logic [ON_W-1:0]  on_end;
    logic [ON_W-1:0]  cnt_ext;

    assign frame_start = (cnt_q == '0) && (idx_q == '0);

    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (cnt_q == CNT_W'(DIGIT_CYCLES - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        // fcnt counts frames begun in the current phase; the phase flips as the next one starts
        if (frame_start) begin
            if (fcnt_q == BF_W'(BLINK_FRAMES)) begin
                fcnt_d  = BF_W'(1);
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + BF_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            fcnt_q  <= '0;
            phase_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            frame_q <= frame_start;
        end
    end

    // Wide enough that the all-ones code lands exactly on DIGIT_CYCLES
    assign on_end  = ((ON_W'(i_brightness) + ON_W'(1)) * ON_W'(DIGIT_CYCLES - GUARD) >> BRIGHT_W)
                     + ON_W'(GUARD);
    assign cnt_ext = ON_W'(cnt_q);

    assign o_idx         = idx_q;
    assign o_frame_start = frame_start;
    assign o_frame       = frame_q;
    assign o_blink_hide  = phase_d;
    assign o_sel_on      = (cnt_ext >= ON_W'(GUARD)) && (cnt_ext < on_end);

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed N-digit seven-segment driver: frame snapshot, leading-zero
// suppression, blink and PWM brightness, with registered pin outputs.
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int DIGIT_CYCLES = 100_000,
    parameter int GUARD        = 8,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [4*N_DIGITS-1:0] i_hex,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic [N_DIGITS-1:0]   i_blank,
    input  logic [N_DIGITS-1:0]   i_blink,
    input  logic                  i_lz_suppress,
    input  logic [BRIGHT_W-1:0]   i_brightness,
    output logic [N_DIGITS-1:0]   o_ldsel,
    output logic [7:0]            o_sseg_n,
    output logic                  o_frame
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [4*N_DIGITS-1:0] hex_q, hex_d;
    logic [N_DIGITS-1:0]   dp_q, dp_d, blank_q, blank_d, blink_q, blink_d;
    logic                  lz_q, lz_d;
    logic [BRIGHT_W-1:0]   bright_q, bright_d;
    logic [N_DIGITS-1:0]   ldsel_q, ldsel_d;
    logic [7:0]            sseg_q, sseg_d;
    logic [N_DIGITS-1:0]   supp;
    logic                  chain;
    logic [IDX_W-1:0]      idx;
    logic                  frame_start, blink_hide, sel_on, dark;
    logic [3:0]            cur_hex;

    sseg_slot_timer #(
        .N_DIGITS    (N_DIGITS),
        .DIGIT_CYCLES(DIGIT_CYCLES),
        .GUARD       (GUARD),
        .BRIGHT_W    (BRIGHT_W),
        .BLINK_FRAMES(BLINK_FRAMES),
        .IDX_W       (IDX_W)
    ) u_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_brightness (bright_d),
        .o_idx        (idx),
        .o_frame_start(frame_start),
        .o_frame      (o_frame),
        .o_blink_hide (blink_hide),
        .o_sel_on     (sel_on)
    );

    // The snapshot is visible from the frame-start cycle itself, so slot 0 never shows stale data
    assign hex_d    = frame_start ? i_hex         : hex_q;
    assign dp_d     = frame_start ? i_dp          : dp_q;
    assign blank_d  = frame_start ? i_blank       : blank_q;
    assign blink_d  = frame_start ? i_blink       : blink_q;
    assign lz_d     = frame_start ? i_lz_suppress : lz_q;
    assign bright_d = frame_start ? i_brightness  : bright_q;

    always_comb begin
        supp  = '0;
        chain = lz_d;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            if (chain && (hex_d[4*k +: 4] == 4'h0) && !dp_d[k] && (k != 0)) begin
                supp[k] = 1'b1;
            end else begin
                chain = 1'b0;
            end
        end
    end

    assign cur_hex = hex_d[4*idx +: 4];
    assign dark    = blank_d[idx] | supp[idx] | (blink_hide & blink_d[idx]);

    always_comb begin
        ldsel_d = '0;
        if (sel_on) begin
            ldsel_d[idx] = 1'b1;
        end
        sseg_d = dark ? SSEG_BLANK_N : {~dp_d[idx], hex_to_sseg_n(cur_hex)};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hex_q    <= '0;
            dp_q     <= '0;
            blank_q  <= '1;
            blink_q  <= '0;
            lz_q     <= 1'b0;
            bright_q <= '0;
            ldsel_q  <= '0;
            sseg_q   <= SSEG_BLANK_N;
        end else begin
            hex_q    <= hex_d;
            dp_q     <= dp_d;
            blank_q  <= blank_d;
            blink_q  <= blink_d;
            lz_q     <= lz_d;
            bright_q <= bright_d;
            ldsel_q  <= ldsel_d;
            sseg_q   <= sseg_d;
        end
    end

    assign o_ldsel  = ldsel_q;
    assign o_sseg_n = sseg_q;

endmodule

// File: doc/sseg_scan_mux.md
# sseg_scan_mux

Parametrised time-multiplexed seven-segment display driver for N digits, sitting between the value-producing logic and the FMC segment and digit-select pins. Each frame latches a snapshot of per-digit hex, decimal-point, blank and blink controls. It then scans the digits with a guard interval, PWM brightness, leading-zero suppression and a frame-rate blink. This block succeeds the fixed 4-digit mux plus external decoders with one configurable block.

## Interface
- N_DIGITS, 4, number of digits scanned (≥1)
- DIGIT_CYCLES, 100_000, clock cycles per digit slot (> GUARD)
- GUARD, 8, cycles at slot start with all digit selects off (anti-ghosting)
- BRIGHT_W, 4, brightness code width
- BLINK_FRAMES, 250, frames per blink half-period

- i_clk  in  1  system clock
- i_rst_n  in  1  reset; one clock; reset is synchronous and active-low
- i_hex  in  4*N_DIGITS  digit values; digit k = [4k+3:4k], digit 0 rightmost
- i_dp  in  N_DIGITS  decimal point on (active-high)
- i_blank  in  N_DIGITS  force digit dark
- i_blink  in  N_DIGITS  digit participates in blink
- i_lz_suppress  in  1  enable leading-zero suppression
- i_brightness  in  BRIGHT_W  duty code, 0 = dimmest, all-ones = full
- o_ldsel  out  N_DIGITS  digit select, active-high, one-hot or zero
- o_sseg_n  out  8  segments active-low, bit7=DP, bits6..0 = G,F,E,D,C,B,A
- o_frame  out  1  one-cycle pulse at frame start

## Operation
- Slot counter cnt counts 0..DIGIT_CYCLES-1. At wrap, digit index idx advances 0..N_DIGITS-1 and then wraps to 0.
- Frame start is cnt==0 && idx==0, which includes the first cycle after reset release. At frame start all inputs are copied into shadow registers, and only the shadow values drive the display.
- Blink phase toggles on every BLINK_FRAMES-th frame start. Phase 1 darkens digits with the shadow blink bit set. Phase resets to 0 (visible).
- Leading-zero suppression:
  - Scan runs from digit N_DIGITS-1 downward.
  - A digit is suppressed while lz is on, its value is 0, all higher digits are suppressed, its dp bit is 0, and it is not digit 0.
  - A dp bit of 1 ends the chain.
- A digit is dark (o_sseg_n = 8'hFF) if it is blanked, suppressed, or blink-hidden. Otherwise the output is the hex decode with DP = ~dp.
- o_ldsel[idx] is asserted when GUARD ≤ cnt < on_end, where on_end = GUARD + (((i_brightness+1)·(DIGIT_CYCLES−GUARD)) >> BRIGHT_W). The brightness code is sampled at frame start. A dark digit still gets its select asserted.
- Reset values: o_ldsel=0, o_sseg_n=8'hFF, o_frame=0, cnt=idx=0, shadows 0 with blank all ones, blink phase 0. Reset mid-frame aborts immediately with no partial slot.

## Timing
- All outputs are registered, with 1-cycle latency from counter state. o_frame is high in the cycle after the cnt==0/idx==0 state.
- o_sseg_n changes only at slot start, during guard, when o_ldsel is 0.
- Input changes mid-frame have no visible effect until the next o_frame.
- on_end uses a width of BRIGHT_W + clog2(DIGIT_CYCLES) + 1 bits with no overflow. The maximum code gives on_end = DIGIT_CYCLES (full after guard).

## Structure
- Package sseg_pkg holds:
  - segment constants, including SSEG_BLANK_N = 8'hFF
  - function hex_to_sseg_n(hex) returning 7 bits active-low
  - the bit-order definition
- Sub-module sseg_slot_timer holds cnt, idx, frame pulse, the blink-phase counter and the PWM compare. The top level holds the shadows, suppression logic and output registers.

## Test plan
Parameters: N=4, DIGIT_CYCLES=16, GUARD=2, BRIGHT_W=2, BLINK_FRAMES=2.
- Reset:
  - Stimulus: hold i_rst_n=0 for 5 cycles, then reset mid-slot.
  - Required: o_ldsel=0 and o_sseg_n=FF throughout reset, then o_frame pulses 1 cycle after release.
  - Required: after the mid-slot reset, the scan restarts at digit 0.
- Full-brightness scan:
  - Stimulus: hex=16'h12AF, brightness=3.
  - Required: o_ldsel goes 0001, 0010, 0100, 1000, each high 14 of 16 cycles.
  - Required: o_sseg_n goes 8E, 88, A4, F9.
- Minimum brightness:
  - Stimulus: brightness=0.
  - Required: each select is high exactly 3 cycles (cnt 2..4), with period 64.
- Leading-zero suppression:
  - Stimulus: hex=16'h0005, lz=1.
  - Required: digits 3..1 show FF and digit 0 shows 92.
  - Stimulus: add dp[2]=1.
  - Required: digit3 FF, digit2 40, digit1 C0, digit0 92.
- Snapshot:
  - Stimulus: change hex in the middle of a frame.
  - Required: the old pattern persists until the next o_frame, and the new pattern appears in the following slot 0.
- Blink:
  - Stimulus: blink=4'b0001.
  - Required: digit 0 is visible in frames 0–1, FF in frames 2–3, visible in frames 4–5. Other digits are unaffected.
